mult_share_scheduler: RTL
=========================

// Module: mult_share_scheduler
// PURPOSE
//  Shares one tt_um_sequential_multiplier_4bit instance among NUM_REQ requesters.
//  - Arbitrates requests round-robin and launches one multiply at a time (mul_in_valid pulse).
//  - Waits for mul_out_done, then returns the product to the winning requester.
//  - Sits between client blocks and the multiplier's ui_in/uio_in/in_valid/out_done/uo_out.
// PARAMETERS
//  NUM_REQ         4   number of requesters (2..8)
//  OPW             4   operand width (a, b)
//  RESW            8   product width (2*OPW)
//  TIMEOUT_CYCLES  32  watchdog limit in WAIT state (used only with MULT_TIMEOUT_EN)
// PORTS
//  clk           in   1             single clock, rising edge
//  reset         in   1             asynchronous, active-low reset
//  req_valid     in   NUM_REQ       per-requester request valid; held until accepted
//  req_a         in   NUM_REQ*OPW   packed operand a, requester i at [i*OPW +: OPW]
//  req_b         in   NUM_REQ*OPW   packed operand b, same packing
//  req_ready     out  NUM_REQ       one-hot accept strobe (combinational, IDLE only)
//  rsp_valid     out  NUM_REQ       one-hot, 1-cycle result strobe to the granted requester
//  rsp_result    out  RESW          product; valid when any rsp_valid bit is set
//  rsp_err       out  1             qualifies rsp_valid: result is a timeout, not a product
//  mul_a         out  OPW           to multiplier a[3:0]
//  mul_b         out  OPW           to multiplier b[3:0]
//  mul_in_valid  out  1             1-cycle start pulse to multiplier
//  mul_out_done  in   1             multiplier completion
//  mul_result    in   RESW          multiplier product
//  busy          out  1             high in any state other than IDLE
// BEHAVIOUR
//  Reset values:
//  - All outputs 0.
//  - FSM in IDLE; round-robin pointer at 0 (requester 0 highest priority).
//  - Operand/result registers 0.
//  FSM states and transitions:
//  - IDLE:  req_ready = rr_grant(req_valid, ptr); req_ready=0 if no req_valid.
//           Handshake = req_valid[i] & req_ready[i].
//           On handshake: latch a/b/grant index; ptr <= i+1 (mod NUM_REQ); -> ISSUE.
//  - ISSUE: mul_a/mul_b drive the latched operands (held stable ISSUE..RESP).
//           mul_in_valid=1 for exactly this cycle; -> WAIT.
//  - WAIT:  on mul_out_done: capture mul_result; -> RESP.
//  - RESP:  rsp_valid[grant]=1 for one cycle; rsp_result = captured product; -> IDLE.
//  Latency:
//  - Accept at T -> mul_in_valid at T+1.
//  - out_done seen at D -> rsp_valid at D+1.
//  - Next accept possible at D+2.
//  Response and request rules:
//  - No backpressure on responses; the requester must capture in the rsp_valid cycle.
//  - mul_out_done outside WAIT (stray, or in the same cycle as ISSUE) is ignored.
//  - A req_valid deasserted before handshake is legal and drops the request.
//  - Operands are sampled only on the handshake cycle.
//  - rsp_result holds its last value between responses.
//  Boundary conditions:
//  - All NUM_REQ valid continuously: strict rotation 0,1,2,3,0... no starvation.
//  - Single requester: it is served back-to-back every cycle it is valid in IDLE.
//  - Reset asserted mid-operation: immediate return to IDLE, in-flight job dropped,
//    no rsp_valid. The multiplier shares the same reset.
//  Arithmetic: the product is passed through unmodified, RESW bits, no truncation.
// CONFIGURATION
//  MULT_TIMEOUT_EN defined:
//  - A counter runs in WAIT. After TIMEOUT_CYCLES cycles without mul_out_done -> RESP.
//  - In that RESP: rsp_result=0 and rsp_err=1.
//  - The counter clears on entering WAIT.
//  MULT_TIMEOUT_EN undefined:
//  - WAIT persists until mul_out_done; rsp_err is tied to 0; no counter is built.
// STRUCTURE
//  Package mult_sched_pkg:
//  - state enum {IDLE, ISSUE, WAIT, RESP}.
//  - OPW/RESW defaults and the TIMEOUT_CYCLES default.
//  Sub-module rr_arbiter:
//  - Parameter N; inputs req[N], ptr; output one-hot grant[N] and grant index.
//  - Purely combinational.
//  Top level holds the FSM, operand/result registers, pointer and optional watchdog.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with req_valid=4'b1111
//    -> all outputs 0, req_ready=0 during reset.
//  - Single request: req0 a=4'd7, b=4'd9; model done 4 cycles after start
//    -> mul_a=7/mul_b=9 with a 1-cycle mul_in_valid; rsp_valid=4'b0001, rsp_result=8'd63.
//  - Contention: req_valid=4'b1111 held, operands i+1 x i+2
//    -> grants in order 0,1,2,3,0; results 2,6,12,20.
//  - Max operands: a=4'hF, b=4'hF on requester 2 -> rsp_valid=4'b0100, rsp_result=8'd225.
//  - Reset mid-WAIT: pull reset low during WAIT
//    -> no rsp_valid, busy=0, the next grant goes to requester 0.
//  - Timeout (MULT_TIMEOUT_EN, TIMEOUT_CYCLES=32), model never asserts done
//    -> rsp_valid exactly 33 cycles after mul_in_valid, with rsp_err=1 and rsp_result=0.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared types and default sizing for the multiplier-sharing scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int NUM_REQ_DEF        = 4;
    localparam int OPW_DEF            = 4;
    localparam int RESW_DEF           = 2 * OPW_DEF;
    localparam int TIMEOUT_CYCLES_DEF = 32;

endpackage

// File: rtl/mult_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans from i_ptr upward (wrapping) and
// grants the first requester found, as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int PTRW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [PTRW-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [PTRW-1:0] o_idx
);

    logic [PTRW-1:0] w_j;
    logic            w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = PTRW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/mult_share_scheduler.sv
// Time-shares one sequential multiplier among NUM_REQ requesters (round-robin).
// Optional WAIT-state watchdog enabled by defining MULT_TIMEOUT_EN.
module mult_share_scheduler
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int OPW            = OPW_DEF,
    parameter int RESW           = RESW_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*OPW-1:0] req_a,
    input  logic [NUM_REQ*OPW-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [RESW-1:0]        rsp_result,
    output logic                   rsp_err,
    output logic [OPW-1:0]         mul_a,
    output logic [OPW-1:0]         mul_b,
    output logic                   mul_in_valid,
    input  logic                   mul_out_done,
    input  logic [RESW-1:0]        mul_result,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t              r_state;
    state_t              w_next;
    logic [PTRW-1:0]     r_ptr;
    logic [PTRW-1:0]     r_gidx;
    logic [PTRW-1:0]     w_gidx;
    logic [NUM_REQ-1:0]  w_grant;
    logic [OPW-1:0]      r_a;
    logic [OPW-1:0]      r_b;
    logic [RESW-1:0]     r_res;
    logic                w_accept;
    logic                w_done;
    logic                w_timeout;

    rr_arbiter #(
        .N    (NUM_REQ),
        .PTRW (PTRW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    // Valid/ready: a requester holds req_valid and its operands; the transfer
    // happens in the cycle where its req_ready bit is also high (IDLE only,
    // and never while reset is asserted). Dropping req_valid early is legal.
    assign req_ready = (r_state == IDLE && reset) ? w_grant : '0;
    assign w_accept  = |req_ready;
    assign w_done    = (r_state == WAIT) && mul_out_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (w_done || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr  <= '0;
            r_gidx <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= req_a[w_gidx*OPW +: OPW];
                r_b    <= req_b[w_gidx*OPW +: OPW];
                r_gidx <= w_gidx;
                r_ptr  <= (w_gidx == PTRW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            if (w_done)         r_res <= mul_result;
            else if (w_timeout) r_res <= '0;
        end
    end

`ifdef MULT_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNTW-1:0] r_cnt;
    logic            r_err;

    // Counter is zeroed in ISSUE so it starts at 0 on the first WAIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ISSUE)     r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
            if (w_done)         r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end

    assign w_timeout = (r_state == WAIT) && !mul_out_done &&
                       (r_cnt == CNTW'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = (r_state == RESP) && r_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign rsp_valid    = (r_state == RESP) ? (NUM_REQ'(1) << r_gidx) : '0;
    assign rsp_result   = r_res;
    assign mul_a        = r_a;
    assign mul_b        = r_b;
    assign mul_in_valid = (r_state == ISSUE);
    assign busy         = (r_state != IDLE);
    assign dbg_state    = r_state;

endmodule
